paddle_render_seq: RTL and testbench

//  Initiator for the paddle renderer's clear/draw pulse handshake; the renderer is the responder.
//  - On each frameTick, runs four phases in order: clear P1, draw P1, clear P2, draw P2.
//  - Forwards the renderer's pixel stream to the VGA adapter as registered x/y/colour/plot.
//  - Reports frame completion and dropped (overrun) frames. Sits between the frame rate divider, the paddle renderer and the VGA adapter.

---
 rtl/paddle_render_pkg.sv | 25 ++
 rtl/paddle_render_seq_if.sv | 38 +++
 rtl/paddle_render_seq_phase_timer.sv | 38 +++
 rtl/paddle_render_seq.sv | 150 +++++++++++++++
 tb/tb_paddle_render_seq.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/paddle_render_pkg.sv
// Shared types and constants for the paddle render sequencer: FSM state
// encodings, screen coordinate width helpers and the colour constants.
package paddle_render_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR1 = 3'd1,
    DRW1 = 3'd2,
    CLR2 = 3'd3,
    DRW2 = 3'd4,
    FIN  = 3'd5
  } state_e;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

  function automatic int x_width(input int screen_x);
    return $clog2(screen_x) + 1;
  endfunction

  function automatic int y_width(input int screen_y);
    return $clog2(screen_y) + 1;
  endfunction

endpackage

// File: rtl/paddle_render_seq_if.sv
// Pulse/done handshake with the paddle renderer plus the pixel bus toward the
// VGA adapter. The sequencer is the master; the renderer side is the slave.
interface paddle_render_seq_if #(
  parameter int X_W = 11,
  parameter int Y_W = 10
);

  logic           pulse_clear1;
  logic           pulse_draw1;
  logic           pulse_clear2;
  logic           pulse_draw2;
  logic           done_clear1;
  logic           done_draw1;
  logic           done_clear2;
  logic           done_draw2;
  logic [X_W-1:0] render_x;
  logic [Y_W-1:0] render_y;
  logic [2:0]     col_in;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;

  modport master (
    output pulse_clear1, pulse_draw1, pulse_clear2, pulse_draw2,
    output vga_x, vga_y, vga_colour, vga_plot,
    input  done_clear1, done_draw1, done_clear2, done_draw2,
    input  render_x, render_y, col_in
  );

  modport slave (
    input  pulse_clear1, pulse_draw1, pulse_clear2, pulse_draw2,
    input  vga_x, vga_y, vga_colour, vga_plot,
    output done_clear1, done_draw1, done_clear2, done_draw2,
    output render_x, render_y, col_in
  );

endinterface

// File: rtl/paddle_render_seq_phase_timer.sv
// Per-phase watchdog counter: cleared on phase entry, counts enabled cycles,
// flags expiry on the LIMIT-th enabled cycle of a phase.
module phase_timer #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = en && (count_q == LAST);

endmodule

// File: rtl/paddle_render_seq.sv
// Clear/draw phase sequencer for both paddles with registered pixel forwarding.
// Optional per-phase abort timer is built when RENDER_TIMEOUT_EN is defined.
module paddle_render_seq
  import paddle_render_pkg::*;
#(
  parameter int SCREEN_X       = 640,
  parameter int SCREEN_Y       = 480,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                frameTick,
  paddle_render_seq_if.master bus,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          missed_frames,
  output logic                timeout_err
);

  localparam int X_W = x_width(SCREEN_X);
  localparam int Y_W = y_width(SCREEN_Y);

  state_e         state_q, state_d;
  logic [3:0]     pulse_q, pulse_d;
  logic [X_W-1:0] vga_x_q, vga_x_d;
  logic [Y_W-1:0] vga_y_q, vga_y_d;
  logic [2:0]     vga_colour_q, vga_colour_d;
  logic           vga_plot_q, vga_plot_d;
  logic [7:0]     missed_q, missed_d;

  logic in_phase;
  logic cur_done;
  logic abort;
  logic advance;

  assign in_phase = (state_q == CLR1) || (state_q == DRW1) ||
                    (state_q == CLR2) || (state_q == DRW2);

  // Only the done strobe belonging to the current phase matters.
  always_comb begin
    cur_done = 1'b0;
    case (state_q)
      CLR1:    cur_done = bus.done_clear1;
      DRW1:    cur_done = bus.done_draw1;
      CLR2:    cur_done = bus.done_clear2;
      DRW2:    cur_done = bus.done_draw2;
      default: cur_done = 1'b0;
    endcase
  end

`ifdef RENDER_TIMEOUT_EN
  logic timer_expire;
  logic timeout_err_q, timeout_err_d;

  phase_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_phase_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (!in_phase || advance),
    .en     (enable && in_phase),
    .expire (timer_expire)
  );

  assign abort         = timer_expire && !cur_done;
  assign timeout_err_d = timeout_err_q || (in_phase && abort);
  assign timeout_err   = timeout_err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_err_d;
    end
  end
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign advance = enable && in_phase && (cur_done || abort);

  always_comb begin
    state_d = state_q;
    if (enable) begin
      case (state_q)
        IDLE:    if (frameTick) state_d = CLR1;
        CLR1:    if (advance)   state_d = DRW1;
        DRW1:    if (advance)   state_d = CLR2;
        CLR2:    if (advance)   state_d = DRW2;
        DRW2:    if (advance)   state_d = FIN;
        FIN:                    state_d = IDLE;
        default:                state_d = IDLE;
      endcase
    end
  end

  // Pulses are registered from the next state so they drop on the done edge.
  always_comb begin
    pulse_d      = {state_d == DRW2, state_d == CLR2, state_d == DRW1, state_d == CLR1};
    vga_plot_d   = enable && (pulse_q != 4'b0000);
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    if (vga_plot_d) begin
      vga_x_d      = bus.render_x;
      vga_y_d      = bus.render_y;
      vga_colour_d = bus.col_in;
    end
    missed_d = missed_q;
    if (enable && frameTick && (state_q != IDLE) && (missed_q != 8'hFF)) begin
      missed_d = missed_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pulse_q      <= 4'b0000;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= BLACK;
      vga_plot_q   <= 1'b0;
      missed_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      pulse_q      <= pulse_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      missed_q     <= missed_d;
    end
  end

  assign bus.pulse_clear1 = pulse_q[0];
  assign bus.pulse_draw1  = pulse_q[1];
  assign bus.pulse_clear2 = pulse_q[2];
  assign bus.pulse_draw2  = pulse_q[3];
  assign bus.vga_x        = vga_x_q;
  assign bus.vga_y        = vga_y_q;
  assign bus.vga_colour   = vga_colour_q;
  assign bus.vga_plot     = vga_plot_q;

  assign busy          = (state_q != IDLE);
  assign frame_done    = (state_q == FIN);
  assign missed_frames = missed_q;

endmodule

// File: tb/tb_paddle_render_seq.sv
// Self-checking bench for paddle_render_seq: phase ordering, pixel forwarding
// scoreboard, overrun saturation, enable stall, reset abort and timeout.
module tb_paddle_render_seq;
  import paddle_render_pkg::*;

  localparam int X_W = x_width(640);
  localparam int Y_W = y_width(480);

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [2:0]     c;
  } pix_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       frameTick;
  logic       busy;
  logic       frame_done;
  logic [7:0] missed_frames;
  logic       timeout_err;
  logic [3:0] pulses;

  int errors = 0;
  int checks = 0;

  int   phase_q[$];
  pix_t pix_q[$];

  paddle_render_seq_if #(.X_W(X_W), .Y_W(Y_W)) rif ();

  paddle_render_seq #(
    .SCREEN_X       (640),
    .SCREEN_Y       (480),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .frameTick     (frameTick),
    .bus           (rif.master),
    .busy          (busy),
    .frame_done    (frame_done),
    .missed_frames (missed_frames),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  assign pulses = {rif.pulse_draw2, rif.pulse_clear2, rif.pulse_draw1, rif.pulse_clear1};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dones(input logic [3:0] v);
    {rif.done_draw2, rif.done_clear2, rif.done_draw1, rif.done_clear1} = v;
  endtask

  function automatic int phase_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 3; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    enable = 1'b1;
    frameTick = 1'b0;
    set_dones(4'b0000);
    rif.render_x = '0;
    rif.render_y = '0;
    rif.col_in = BLACK;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    step();
  endtask

  // Reset state, then an asynchronous reset in the middle of CLR2.
  task automatic test_reset();
    resetn = 1'b0;
    enable = 1'b1;
    frameTick = 1'b0;
    set_dones(4'b0000);
    rif.render_x = '0;
    rif.render_y = '0;
    rif.col_in = BLACK;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pulses, rif.vga_plot, busy, frame_done, timeout_err} !== 8'h00)
      $display("[TB] FAIL reset_flags: got %b required 00000000",
               {pulses, rif.vga_plot, busy, frame_done, timeout_err});
    if ({pulses, rif.vga_plot, busy, frame_done, timeout_err} !== 8'h00) errors++;
    checks++;
    if ({rif.vga_x, rif.vga_y, rif.vga_colour, missed_frames} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: x=%0d y=%0d c=%0d missed=%0d required all 0",
               rif.vga_x, rif.vga_y, rif.vga_colour, missed_frames);
    end
    resetn = 1'b1;
    step();
    frameTick = 1'b1; step(); frameTick = 1'b0;
    set_dones(4'b0001); step(); set_dones(4'b0000);
    set_dones(4'b0010); step(); set_dones(4'b0000);
    rif.render_x = 11'd123; rif.render_y = 10'd45; rif.col_in = WHITE;
    step();
    checks++;
    if (pulses !== 4'b0100 || rif.vga_x !== 11'd123) begin
      errors++;
      $display("[TB] FAIL reset_precond_clr2: pulses=%b x=%0d required 0100 x=123", pulses, rif.vga_x);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({pulses, rif.vga_plot, busy, frame_done} !== 7'd0 || rif.vga_x !== '0 || rif.vga_colour !== BLACK) begin
      errors++;
      $display("[TB] FAIL reset_async: pulses=%b plot=%b busy=%b x=%0d c=%0d required all 0",
               pulses, rif.vga_plot, busy, rif.vga_x, rif.vga_colour);
    end
    @(posedge clk); #1;
    checks++;
    if ({pulses, rif.vga_plot, busy, frame_done} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_hold: pulses=%b plot=%b busy=%b required 0", pulses, rif.vga_plot, busy);
    end
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (pulses !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_release_idle: cycle %0d pulses=%b busy=%b required 0000/0", i, pulses, busy);
      end
    end
  endtask

  // Nominal frame; each done arrives three cycles after its pulse rises.
  task automatic test_nominal();
    logic [3:0] cur;
    int idx, prev, width, fd_count, expd;
    do_reset();
    frameTick = 1'b1; step(); frameTick = 1'b0;
    for (int p = 0; p < 4; p++) phase_q.push_back(p);
    prev = -1; width = 0; fd_count = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      cur = pulses;
      idx = phase_idx(cur);
      checks++;
      if ($countones(cur) > 1) begin
        errors++;
        $display("[TB] FAIL nominal_overlap: pulses=%b required at most one high", cur);
      end
      if (idx != prev) begin
        if (prev >= 0) begin
          checks++;
          if (width != 3) begin
            errors++;
            $display("[TB] FAIL nominal_width: phase %0d width %0d required 3", prev, width);
          end
        end
        if (idx >= 0) begin
          expd = (phase_q.size() > 0) ? phase_q.pop_front() : -2;
          checks++;
          if (idx != expd) begin
            errors++;
            $display("[TB] FAIL nominal_order: phase %0d required %0d", idx, expd);
          end
        end
        width = 0;
      end
      if (idx >= 0) width++;
      if (frame_done === 1'b1) fd_count++;
      set_dones(4'b0000);
      if (idx >= 0 && width == 3) set_dones(4'b0001 << idx);
      prev = idx;
      step();
    end
    set_dones(4'b0000);
    checks++;
    if (fd_count != 1 || phase_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nominal_frame_done: frame_done cycles=%0d left=%0d busy=%b required 1/0/0",
               fd_count, phase_q.size(), busy);
    end
  endtask

  // Pixel forwarding scoreboard across a whole frame, then hold in IDLE.
  task automatic test_pixel_path();
    pix_t sent, got, expd, last;
    logic [3:0] cur;
    int idx, prev, w;
    logic fixed_used, pushed;
    do_reset();
    frameTick = 1'b1; step(); frameTick = 1'b0;
    prev = -1; w = 0; fixed_used = 1'b0; last = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      cur = pulses;
      idx = phase_idx(cur);
      set_dones(4'b0000);
      pushed = 1'b0;
      if (idx != prev) w = 0;
      if (idx >= 0) begin
        w++;
        if (idx == 1 && !fixed_used) begin
          sent.x = 11'd10; sent.y = 10'd240; sent.c = WHITE;
          fixed_used = 1'b1;
        end else begin
          sent.x = X_W'($urandom_range(0, 639));
          sent.y = Y_W'($urandom_range(0, 479));
          sent.c = 3'($urandom_range(0, 7));
        end
        rif.render_x = sent.x; rif.render_y = sent.y; rif.col_in = sent.c;
        pix_q.push_back(sent);
        last = sent;
        pushed = 1'b1;
        if (w == 2) set_dones(4'b0001 << idx);
      end
      prev = idx;
      step();
      checks++;
      if (rif.vga_plot !== pushed) begin
        errors++;
        $display("[TB] FAIL pixel_plot: cycle %0d plot=%b required %b", cyc, rif.vga_plot, pushed);
      end
      if (pushed) begin
        expd = pix_q.pop_front();
        got = '{x: rif.vga_x, y: rif.vga_y, c: rif.vga_colour};
        checks++;
        if (got !== expd) begin
          errors++;
          $display("[TB] FAIL pixel_data: got x=%0d y=%0d c=%0d required x=%0d y=%0d c=%0d",
                   got.x, got.y, got.c, expd.x, expd.y, expd.c);
        end
      end
    end
    set_dones(4'b0000);
    rif.render_x = 11'd7; rif.render_y = 10'd7; rif.col_in = 3'd2;
    step();
    checks++;
    if (rif.vga_plot !== 1'b0 || rif.vga_x !== last.x || rif.vga_y !== last.y ||
        rif.vga_colour !== last.c || !fixed_used || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pixel_idle_hold: plot=%b x=%0d y=%0d c=%0d busy=%b required 0 x=%0d y=%0d c=%0d busy=0",
               rif.vga_plot, rif.vga_x, rif.vga_y, rif.vga_colour, busy, last.x, last.y, last.c);
    end
  endtask

  // Continuous ticks with no done: counter saturates, frame stays in CLR1.
  task automatic test_overrun();
    int expd;
    do_reset();
    frameTick = 1'b1;
    step();
    checks++;
    if (missed_frames !== 8'd0 || pulses !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL overrun_start: missed=%0d pulses=%b required 0/0001", missed_frames, pulses);
    end
    expd = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      expd = (expd < 255) ? expd + 1 : 255;
      if (i == 9 || i == 254 || i == 255 || i == 299) begin
        checks++;
        if (missed_frames !== 8'(expd)) begin
          errors++;
          $display("[TB] FAIL overrun_count: after %0d ticks missed=%0d required %0d", i + 1, missed_frames, expd);
        end
      end
    end
    frameTick = 1'b0;
    checks++;
    if (pulses !== 4'b0001 || busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_state: pulses=%b busy=%b terr=%b required 0001/1/0", pulses, busy, timeout_err);
    end
  endtask

  // enable=0 freezes the FSM and suppresses plot; stale dones are forgotten.
  task automatic test_enable_stall();
    do_reset();
    enable = 1'b0; frameTick = 1'b1;
    step();
    frameTick = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_idle_tick: busy=%b required 0", busy);
    end
    enable = 1'b1; frameTick = 1'b1; step(); frameTick = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rif.done_clear1 = (i % 2 == 0);
      frameTick = (i == 4);
      step();
      checks++;
      if (pulses !== 4'b0001 || rif.vga_plot !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_freeze: cycle %0d pulses=%b plot=%b required 0001/0", i, pulses, rif.vga_plot);
      end
    end
    enable = 1'b1; frameTick = 1'b0; set_dones(4'b0000);
    checks++;
    if (missed_frames !== 8'd0) begin
      errors++;
      $display("[TB] FAIL stall_missed: missed=%0d required 0", missed_frames);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pulses !== 4'b0001 || rif.vga_plot !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_wait_fresh: cycle %0d pulses=%b plot=%b required 0001/1", i, pulses, rif.vga_plot);
      end
    end
    rif.done_clear1 = 1'b1; step(); rif.done_clear1 = 1'b0;
    checks++;
    if (pulses !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL stall_resume: pulses=%b required 0010", pulses);
    end
  endtask

  // Wrong-phase done, done plus tick together, tick in FIN, tick in IDLE.
  task automatic test_back_to_back();
    do_reset();
    frameTick = 1'b1; step(); frameTick = 1'b0;
    set_dones(4'b0010); step(); set_dones(4'b0000);
    checks++;
    if (pulses !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL b2b_wrong_done: pulses=%b required 0001", pulses);
    end
    set_dones(4'b0001); frameTick = 1'b1; step(); set_dones(4'b0000); frameTick = 1'b0;
    checks++;
    if (pulses !== 4'b0010 || missed_frames !== 8'd1) begin
      errors++;
      $display("[TB] FAIL b2b_done_tick: pulses=%b missed=%0d required 0010/1", pulses, missed_frames);
    end
    set_dones(4'b0010); step();
    set_dones(4'b0100); step();
    set_dones(4'b1000); step(); set_dones(4'b0000);
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b1 || pulses !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL b2b_fin: frame_done=%b busy=%b pulses=%b required 1/1/0000", frame_done, busy, pulses);
    end
    frameTick = 1'b1; step();
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || missed_frames !== 8'd2) begin
      errors++;
      $display("[TB] FAIL b2b_fin_tick: busy=%b frame_done=%b missed=%0d required 0/0/2", busy, frame_done, missed_frames);
    end
    step(); frameTick = 1'b0;
    checks++;
    if (pulses !== 4'b0001 || missed_frames !== 8'd2) begin
      errors++;
      $display("[TB] FAIL b2b_idle_tick: pulses=%b missed=%0d required 0001/2", pulses, missed_frames);
    end
  endtask

  // Phase with no done: aborts after 16 cycles when the timer is built in.
  task automatic test_timeout();
    int cnt;
    do_reset();
    frameTick = 1'b1; step(); frameTick = 1'b0;
    cnt = 0;
    while (pulses === 4'b0001 && cnt < 40) begin
      cnt++;
      step();
    end
`ifdef RENDER_TIMEOUT_EN
    checks++;
    if (cnt != 16 || timeout_err !== 1'b1 || pulses !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL timeout_abort: clr1 cycles=%0d terr=%b pulses=%b required 16/1/0010", cnt, timeout_err, pulses);
    end
`else
    checks++;
    if (cnt != 40 || timeout_err !== 1'b0 || pulses !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL timeout_disabled: clr1 cycles=%0d terr=%b pulses=%b required 40/0/0001", cnt, timeout_err, pulses);
    end
`endif
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal();
    test_pixel_path();
    test_overrun();
    test_enable_stall();
    test_back_to_back();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
